truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Sequential response-side checker for the team's combinational lab gate blocks.
- On a start request it drives every input vector 0 .. 2^N_IN-1 into a combinational DUT, waits for the output to settle, and samples the single-bit DUT output.
- Each sample is compared against a golden truth table, and the block reports mismatch count, first failing vector and pass/fail.
- It replaces the hand-written exhaustive stimulus sequences, so gate-level exercises can be checked in hardware or in a self-checking bench.

Parameters:
- N_IN, 4: number of DUT inputs; legal range 1..8.
- SETTLE, 1: cycles each vector is held before sampling; legal range 1..255.

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: run request; sampled only in IDLE.
- expected, input, 2^N_IN: golden table. Bit i is the required output for input vector i, with dut_in[N_IN-1] as the MSB. Latched at start.
- dut_in, output, N_IN: vector driven to the DUT.
- dut_out, input, 1: DUT response.
- busy, output, 1: high from the edge that accepts start until the edge that enters DONE.
- done, output, 1: one-cycle pulse at end of run.
- pass, output, 1: err_count==0 for the last completed run.
- err_count, output, N_IN+1: mismatches in the last or current run; saturation is impossible, maximum 2^N_IN.
- first_fail, output, N_IN: lowest failing vector.
- first_fail_valid, output, 1: first_fail holds a real value.

Behaviour:
- Reset, asynchronous, takes effect at any time including mid-run:
  - state=IDLE.
  - dut_in, err_count, first_fail, first_fail_valid, busy, done, pass all 0.
  - Latched table cleared.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 at edge E0 latches expected and clears err_count, first_fail, first_fail_valid, pass.
  - Also sets dut_in=0, wait counter=0, busy=1, and moves to WAIT.
- WAIT:
  - Counter increments each edge.
  - When counter==SETTLE-1 the next edge moves to SAMPLE.
  - dut_in is held, so the vector is stable for SETTLE cycles before sampling.
- SAMPLE (one cycle):
  - On its closing edge, compare dut_out with table[dut_in].
  - On mismatch, err_count+=1. If first_fail_valid=0, set first_fail=dut_in and first_fail_valid=1.
  - If dut_in==2^N_IN-1, go to DONE. Otherwise dut_in+=1, counter=0, go to WAIT.
  - dut_in never wraps within a run.
- Each vector occupies exactly SETTLE+1 edges.
- The final compare happens at edge E0 + 2^N_IN*(SETTLE+1). At that edge: state=DONE, busy=0, done=1, pass=(final err_count==0).
- DONE:
  - Lasts one cycle; next edge returns to IDLE with done=0.
  - start during DONE is ignored.
- start in WAIT or SAMPLE is ignored; a run cannot be restarted except via IDLE.
- After the run, err_count, first_fail, first_fail_valid and pass hold until the next accepted start or reset.
- In IDLE, dut_in holds its last value.
- expected changing after start has no effect on the current run.
- dut_out is used only at SAMPLE edges.

Optional Feature:
- Macro TT_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatching SAMPLE records err_count=1 and first_fail, then goes directly to DONE with pass=0 and dut_in left at the failing vector. A fully passing run behaves identically to the undefined case.
- Undefined: the full sweep always runs. No port differences.

Test Plan:
1. N_IN=2, SETTLE=1, expected=4'b0110, bench dut_out = dut_in[1]^dut_in[0], start pulse -> done pulse 8 edges after start, pass=1, err_count=0, first_fail_valid=0.
2. Same DUT, expected=4'b1110 -> err_count=1, first_fail=2'd3, first_fail_valid=1, pass=0.
3. N_IN=3, SETTLE=2, bench DUT g=ac|b~c|ab, expected=8'hE4 -> pass=1 at edge 24; dut_in steps 0..7, each value held 3 cycles.
4. N_IN=4, dut_out tied 1, expected=0 -> err_count=5'b10000, first_fail=0, pass=0. With TT_CHK_STOP_ON_FAIL_EN: done 2 edges after start, err_count=1.
5. N_IN=4, SETTLE=3, extra start pulses while busy -> ignored, done exactly once at edge 64.
6. Assert rst_n=0 while dut_in=5 -> all outputs 0 immediately, without a clock edge. After release, a new start completes normally.

Source files
------------

// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Sequential exhaustive checker for a single-output combinational block.
//   A run sweeps dut_in through 0 .. 2^N_IN-1. Each vector is held for
//   SETTLE cycles, and then dut_out is sampled for one cycle and compared
//   against the golden table that was latched when the run started.
//
// Parameters
//   N_IN   : number of DUT inputs (1..8)
//   SETTLE : cycles each vector is held before it is sampled (1..255)
//
// Ports
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   start            : run request, honoured only in IDLE
//   expected         : golden table; bit i is the required output for vector i
//   dut_in           : vector driven to the block under test
//   dut_out          : response of the block under test
//   busy             : a run is in progress (WAIT/SAMPLE)
//   done             : one-cycle pulse when the run ends
//   pass             : last completed run had no mismatches
//   err_count        : mismatches in the last or current run
//   first_fail       : lowest failing vector
//   first_fail_valid : first_fail holds a recorded vector
//   dbg_state        : current FSM state (0 IDLE, 1 WAIT, 2 SAMPLE, 3 DONE)
//
// Build option
//   TT_CHK_STOP_ON_FAIL_EN : when defined, the first mismatch ends the run
//                            immediately, leaving dut_in at the failing vector.
//
// Handshake: start is a level sampled on a rising edge while in IDLE; any
// start seen in WAIT, SAMPLE or DONE is dropped. done pulses for exactly one
// cycle, and the result outputs stay stable from then until the next
// accepted start.

module truth_table_checker #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_fail,
    output logic                   first_fail_valid,
    output logic [1:0]             dbg_state
);

    localparam int NV = 1 << N_IN;
    localparam logic [7:0]    CNT_LAST = 8'(SETTLE - 1);
    localparam logic [N_IN:0] ERR_ONE  = (N_IN+1)'(1);
    localparam logic [N_IN-1:0] IN_ONE = N_IN'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state,   w_state_nx;
    logic [NV-1:0]     r_table,   w_table_nx;
    logic [N_IN-1:0]   r_dut_in,  w_dut_in_nx;
    logic [7:0]        r_cnt,     w_cnt_nx;
    logic [N_IN:0]     r_err,     w_err_nx;
    logic [N_IN-1:0]   r_ff,      w_ff_nx;
    logic              r_ffv,     w_ffv_nx;
    logic              r_busy,    w_busy_nx;
    logic              r_done,    w_done_nx;
    logic              r_pass,    w_pass_nx;

    logic              w_mismatch;
    logic              w_stop;

    assign w_mismatch = (dut_out != r_table[r_dut_in]);

`ifdef TT_CHK_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_table_nx  = r_table;
        w_dut_in_nx = r_dut_in;
        w_cnt_nx    = r_cnt;
        w_err_nx    = r_err;
        w_ff_nx     = r_ff;
        w_ffv_nx    = r_ffv;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_pass_nx   = r_pass;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_table_nx  = expected;
                    w_err_nx    = '0;
                    w_ff_nx     = '0;
                    w_ffv_nx    = 1'b0;
                    w_pass_nx   = 1'b0;
                    w_dut_in_nx = '0;
                    w_cnt_nx    = '0;
                    w_busy_nx   = 1'b1;
                    w_state_nx  = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nx = r_cnt + 8'd1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_mismatch) begin
                    w_err_nx = r_err + ERR_ONE;
                    if (!r_ffv) begin
                        w_ff_nx  = r_dut_in;
                        w_ffv_nx = 1'b1;
                    end
                end
                // The last vector (all ones) ends the sweep, so dut_in
                // never wraps back to zero inside a run.
                if ((r_dut_in == '1) || w_stop) begin
                    w_state_nx = S_DONE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_pass_nx  = (w_err_nx == '0);
                end else begin
                    w_dut_in_nx = r_dut_in + IN_ONE;
                    w_cnt_nx    = '0;
                    w_state_nx  = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_table  <= '0;
            r_dut_in <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_ff     <= '0;
            r_ffv    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_table  <= w_table_nx;
            r_dut_in <= w_dut_in_nx;
            r_cnt    <= w_cnt_nx;
            r_err    <= w_err_nx;
            r_ff     <= w_ff_nx;
            r_ffv    <= w_ffv_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_pass   <= w_pass_nx;
        end
    end

    assign dut_in           = r_dut_in;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail       = r_ff;
    assign first_fail_valid = r_ffv;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    localparam int EW = 37;  // {id[1:0], pass, ffv, ff[7:0], err[8:0], lat[15:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: N_IN=2, SETTLE=1, XOR ----------------
    logic        start2 = 1'b0;
    logic [3:0]  expected2 = '0;
    logic [1:0]  dut_in2;
    logic        dut_out2;
    logic        busy2, done2, pass2, ffv2;
    logic [2:0]  err2;
    logic [1:0]  ff2;
    logic [1:0]  dbg2;
    assign dut_out2 = dut_in2[1] ^ dut_in2[0];

    truth_table_checker #(.N_IN(2), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2),
        .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .first_fail(ff2),
        .first_fail_valid(ffv2), .dbg_state(dbg2)
    );

    // ---------------- DUT B: N_IN=3, SETTLE=2, g = ac | b~c | ab ----------------
    logic        start3 = 1'b0;
    logic [7:0]  expected3 = '0;
    logic [2:0]  dut_in3;
    logic        dut_out3;
    logic        busy3, done3, pass3, ffv3;
    logic [3:0]  err3;
    logic [2:0]  ff3;
    logic [1:0]  dbg3;
    assign dut_out3 = (dut_in3[2] & dut_in3[0]) | (dut_in3[1] & ~dut_in3[0]) |
                      (dut_in3[2] & dut_in3[1]);

    truth_table_checker #(.N_IN(3), .SETTLE(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected3),
        .dut_in(dut_in3), .dut_out(dut_out3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .first_fail(ff3),
        .first_fail_valid(ffv3), .dbg_state(dbg3)
    );

    // ---------------- DUT C: N_IN=4, SETTLE=3, tie-1 or buffer of bit 0 ----------------
    logic        start4 = 1'b0;
    logic [15:0] expected4 = '0;
    logic        tie1 = 1'b0;
    logic [3:0]  dut_in4;
    logic        dut_out4;
    logic        busy4, done4, pass4, ffv4;
    logic [4:0]  err4;
    logic [3:0]  ff4;
    logic [1:0]  dbg4;
    assign dut_out4 = tie1 ? 1'b1 : dut_in4[0];

    truth_table_checker #(.N_IN(4), .SETTLE(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected(expected4),
        .dut_in(dut_in4), .dut_out(dut_out4), .busy(busy4), .done(done4),
        .pass(pass4), .err_count(err4), .first_fail(ff4),
        .first_fail_valid(ffv4), .dbg_state(dbg4)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int start_edge = 0;

    function automatic logic [EW-1:0] mk(input int id, input bit p, input bit fv,
                                         input int ff, input int err, input int lat);
        return {2'(id), p, fv, 8'(ff), 9'(err), 16'(lat)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on every done pulse, pop the oldest expectation and compare.
    task automatic run_monitor();
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        forever begin
            @(negedge clk);
            if (done2 || done3 || done4) begin
                if (done2)      a = mk(1, pass2, ffv2, int'(ff2), int'(err2), cyc - start_edge);
                else if (done3) a = mk(2, pass3, ffv3, int'(ff3), int'(err3), cyc - start_edge);
                else            a = mk(3, pass4, ffv4, int'(ff4), int'(err4), cyc - start_edge);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got %h expected none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL run_result: got id=%0d pass=%0b ffv=%0b ff=%0d err=%0d lat=%0d expected id=%0d pass=%0b ffv=%0b ff=%0d err=%0d lat=%0d",
                                 a[36:35], a[34], a[33], a[32:25], a[24:16], a[15:0],
                                 e[36:35], e[34], e[33], e[32:25], e[24:16], e[15:0]);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input int id, input logic [15:0] tbl, input logic [EW-1:0] expv,
                         input bit push);
        @(negedge clk);
        case (id)
            1: begin expected2 = tbl[3:0]; start2 = 1'b1; end
            2: begin expected3 = tbl[7:0]; start3 = 1'b1; end
            default: begin expected4 = tbl; start4 = 1'b1; end
        endcase
        start_edge = cyc + 1;
        if (push) exp_q.push_back(expv);
        @(negedge clk);
        start2 = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_all_done(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        fork
            run_monitor();
        join_none

        // Reset state
        #12;
        chk("rst_dut_in2", 32'(dut_in2), 0);
        chk("rst_busy2",   32'(busy2), 0);
        chk("rst_done2",   32'(done2), 0);
        chk("rst_pass2",   32'(pass2), 0);
        chk("rst_err2",    32'(err2), 0);
        chk("rst_ffv2",    32'(ffv2), 0);
        chk("rst_state3",  32'(dbg3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: XOR, matching table
        issue(1, 16'h0006, mk(1, 1, 0, 0, 0, 8), 1'b1);
        chk("t1_busy", 32'(busy2), 1);
        wait_all_done(40, "t1_timeout");

        // 2: XOR, table wrong at vector 3 (last vector, same latency either build)
        issue(1, 16'h000E, mk(1, 0, 1, 3, 1, 8), 1'b1);
        wait_all_done(40, "t2_timeout");
        chk("t2_hold_dut_in", 32'(dut_in2), 3);

        // 3: three-input gate, 0xE4; table input changed after start is ignored
        issue(2, 16'h00E4, mk(2, 1, 0, 0, 0, 24), 1'b1);
        expected3 = 8'h00;
        for (int t = 0; t < 24; t++) begin
            chk($sformatf("t3_dut_in_%0d", t), 32'(dut_in3), 32'(t / 3));
            if (t == 12) chk("t3_busy_mid", 32'(busy3), 1);
            @(negedge clk);
        end
        wait_all_done(10, "t3_timeout");

        // 4: output tied high against all-zero table
        tie1 = 1'b1;
`ifdef TT_CHK_STOP_ON_FAIL_EN
        issue(3, 16'h0000, mk(3, 0, 1, 0, 1, 4), 1'b1);
`else
        issue(3, 16'h0000, mk(3, 0, 1, 0, 16, 64), 1'b1);
`endif
        wait_all_done(120, "t4_timeout");
        repeat (3) @(negedge clk);
`ifdef TT_CHK_STOP_ON_FAIL_EN
        chk("t4_hold_err", 32'(err4), 1);
        chk("t4_hold_dut_in", 32'(dut_in4), 0);
`else
        chk("t4_hold_err", 32'(err4), 16);
        chk("t4_hold_dut_in", 32'(dut_in4), 15);
`endif
        chk("t4_hold_pass", 32'(pass4), 0);

        // 5: extra start pulses while busy and during DONE are ignored
        tie1 = 1'b0;
        issue(3, 16'hAAAA, mk(3, 1, 0, 0, 0, 64), 1'b1);
        for (int c = 1; c <= 58; c++) begin
            start4 = (c == 5 || c == 20 || c == 40);
            @(negedge clk);
        end
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_done_seen", 32'(done4), 1);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("t5_busy_after", 32'(busy4), 0);
        chk("t5_state_idle", 32'(dbg4), 0);
        wait_all_done(10, "t5_timeout");
        repeat (3) @(negedge clk);
        chk("t5_no_restart", 32'(busy4), 0);

        // 6: asynchronous reset mid-run at dut_in == 5
`ifdef TT_CHK_STOP_ON_FAIL_EN
        tie1 = 1'b0;
        issue(3, 16'hAAAA, '0, 1'b0);
`else
        tie1 = 1'b1;
        issue(3, 16'h0000, '0, 1'b0);
`endif
        n = 0;
        while (dut_in4 != 4'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_5", 32'(dut_in4), 5);
`ifndef TT_CHK_STOP_ON_FAIL_EN
        chk("t6_err_before", 32'(err4), 5);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("t6_dut_in", 32'(dut_in4), 0);
        chk("t6_err",    32'(err4), 0);
        chk("t6_ff",     32'(ff4), 0);
        chk("t6_ffv",    32'(ffv4), 0);
        chk("t6_busy",   32'(busy4), 0);
        chk("t6_done",   32'(done4), 0);
        chk("t6_pass",   32'(pass4), 0);
        chk("t6_state",  32'(dbg4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tie1 = 1'b0;
        issue(3, 16'hAAAA, mk(3, 1, 0, 0, 0, 64), 1'b1);
        wait_all_done(120, "t6_rerun_timeout");

        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
